phy_tx_lane_sched: RTL and testbench

//  Transmit scheduler in front of the two-lane PHY TX serializers. Accepts 32-bit words via

---
 rtl/phy_tx_lane_sched_pkg.sv | 20 ++
 rtl/phy_tx_lane_sched_com_cnt.sv | 29 ++
 rtl/phy_tx_lane_sched.sv | 100 ++++++++++
 tb/tb_phy_tx_lane_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_lane_sched_pkg.sv
// Shared symbol defaults and FSM encoding for the two-lane PHY TX scheduler.
package phy_tx_lane_sched_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_IDLE = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_COMS = 3'd4
    } state_t;

    // States in which a new word or a forced COM slot may be scheduled.
    function automatic logic is_open(state_t s);
        return (s == ST_IDLE) || (s == ST_LO) || (s == ST_COMS);
    endfunction

endpackage

// File: rtl/phy_tx_lane_sched_com_cnt.sv
// Word counter between forced COM slots: saturates at COM_INTERVAL, cleared when the slot is taken.
module phy_tx_com_cnt #(
    parameter int COM_INTERVAL = 0
) (
    input  logic clk,
    input  logic reset_L,
    input  logic inc,
    input  logic clr,
    output logic com_due
);

    localparam int CNT_W = (COM_INTERVAL < 2) ? 1 : $clog2(COM_INTERVAL + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(COM_INTERVAL);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign com_due = (COM_INTERVAL != 0) && (cnt == LIMIT);

endmodule

// File: rtl/phy_tx_lane_sched.sv
// Two-lane TX scheduler: SYNC training, idle fill, periodic COM slots and
// byte-striping of 32-bit words as {byte3,byte2} then {byte1,byte0}.
module phy_tx_lane_sched
    import phy_tx_lane_sched_pkg::*;
#(
    parameter int         SYNC_CYCLES  = 4,
    parameter int         COM_INTERVAL = 0,
    parameter logic [7:0] COM_SYM      = COM_SYM_DEF,
    parameter logic [7:0] IDL_SYM      = IDL_SYM_DEF
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  lane0_out,
    output logic [7:0]  lane1_out,
    output logic        lane_k_out,
    output logic        sync_done
);

    localparam int SC_W = $clog2(SYNC_CYCLES + 1);

    state_t          state;
    logic [SC_W-1:0] sync_cnt;
    logic [15:0]     held;
    logic            com_due;
    logic            open_st;
    logic            accept;

    assign open_st   = is_open(state);
    assign ready_out = open_st && !com_due;
    assign accept    = valid_in && ready_out;

    // Clearing on entry to COMS lets the COMS cycle itself accept the next word.
    phy_tx_com_cnt #(
        .COM_INTERVAL(COM_INTERVAL)
    ) u_com_cnt (
        .clk    (clk),
        .reset_L(reset_L),
        .inc    (accept),
        .clr    (open_st && com_due),
        .com_due(com_due)
    );

    // NOTE: the held low half is reset too, so a word cut off by reset can never reappear on the lanes.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= ST_SYNC;
            sync_cnt   <= '0;
            held       <= '0;
            lane0_out  <= 8'h00;
            lane1_out  <= 8'h00;
            lane_k_out <= 1'b0;
            sync_done  <= 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    lane_k_out <= 1'b1;
                    if (sync_cnt == SC_W'(SYNC_CYCLES)) begin
                        state     <= ST_IDLE;
                        lane0_out <= IDL_SYM;
                        lane1_out <= IDL_SYM;
                        sync_done <= 1'b1;
                    end else begin
                        sync_cnt  <= sync_cnt + 1'b1;
                        lane0_out <= COM_SYM;
                        lane1_out <= COM_SYM;
                    end
                end
                ST_HI: begin
                    state      <= ST_LO;
                    lane0_out  <= held[15:8];
                    lane1_out  <= held[7:0];
                    lane_k_out <= 1'b0;
                end
                default: begin
                    if (com_due) begin
                        state      <= ST_COMS;
                        lane0_out  <= COM_SYM;
                        lane1_out  <= COM_SYM;
                        lane_k_out <= 1'b1;
                    end else if (accept) begin
                        state      <= ST_HI;
                        lane0_out  <= data_in[31:24];
                        lane1_out  <= data_in[23:16];
                        held       <= data_in[15:0];
                        lane_k_out <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        lane0_out  <= IDL_SYM;
                        lane1_out  <= IDL_SYM;
                        lane_k_out <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Bench for phy_tx_lane_sched: two instances (no COM slots / COM every 2 words) against a symbol-stream model.
module tb_phy_tx_lane_sched;

    localparam int SYNC = 4;

    logic        clk = 1'b0;
    logic        reset_L = 1'b1;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;

    logic        rdy0, k0, sd0, rdy1, k1, sd1;
    logic [7:0]  a0, b0, a1, b1;

    int chk = 0;
    int err = 0;
    bit live = 0;

    always #5 clk = ~clk;

    phy_tx_lane_sched #(.SYNC_CYCLES(SYNC), .COM_INTERVAL(0)) u_dut0 (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_out(rdy0), .lane0_out(a0), .lane1_out(b0), .lane_k_out(k0), .sync_done(sd0)
    );

    phy_tx_lane_sched #(.SYNC_CYCLES(SYNC), .COM_INTERVAL(2)) u_dut1 (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .ready_out(rdy1), .lane0_out(a1), .lane1_out(b1), .lane_k_out(k1), .sync_done(sd1)
    );

    // ---------------- reference model: what symbol goes out next ----------------
    int          com_sent [2];
    bit          synced   [2];
    bit          pend     [2];
    logic [15:0] pend_b   [2];
    int          words    [2];
    logic [7:0]  e_a      [2];
    logic [7:0]  e_b      [2];
    logic        e_k      [2];
    logic        e_sd     [2];

    function automatic int intv(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit due(int i);
        return (intv(i) != 0) && (words[i] == intv(i));
    endfunction

    function automatic bit exp_ready(int i);
        return synced[i] && !pend[i] && !due(i);
    endfunction

    task automatic emit(int i, logic [7:0] x, logic [7:0] y, logic k);
        e_a[i] = x;
        e_b[i] = y;
        e_k[i] = k;
    endtask

    task automatic model_step(int i);
        if (!reset_L) begin
            emit(i, 8'h00, 8'h00, 1'b0);
            e_sd[i] = 1'b0;
            com_sent[i] = 0;
            synced[i] = 0;
            pend[i] = 0;
            words[i] = 0;
        end else if (!synced[i]) begin
            if (com_sent[i] < SYNC) begin
                emit(i, 8'hBC, 8'hBC, 1'b1);
                com_sent[i]++;
            end else begin
                emit(i, 8'h7C, 8'h7C, 1'b1);
                synced[i] = 1;
                e_sd[i] = 1'b1;
            end
        end else if (pend[i]) begin
            emit(i, pend_b[i][15:8], pend_b[i][7:0], 1'b0);
            pend[i] = 0;
        end else if (due(i)) begin
            emit(i, 8'hBC, 8'hBC, 1'b1);
            words[i] = 0;
        end else if (valid_in) begin
            emit(i, data_in[31:24], data_in[23:16], 1'b0);
            pend_b[i] = data_in[15:0];
            pend[i] = 1;
            if (words[i] < intv(i)) words[i]++;
        end else begin
            emit(i, 8'h7C, 8'h7C, 1'b1);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- checking ----------------
    function automatic logic [31:0] dut_pack(int i);
        if (i == 0) return {13'b0, a0, b0, k0, sd0, rdy0};
        return {13'b0, a1, b1, k1, sd1, rdy1};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got {l0,l1,k,sd,rdy}=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(int i, string name, logic [7:0] x, logic [7:0] y, logic k, logic sd, logic r);
        check(name, dut_pack(i), {13'b0, x, y, k, sd, r});
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++)
                check($sformatf("model_inst%0d", i), dut_pack(i),
                      {13'b0, e_a[i], e_b[i], e_k[i], e_sd[i], exp_ready(i)});
        end
    end

    task automatic do_reset();
        reset_L = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // Hold a word until instance i takes it; returns at the negedge of its HI cycle.
    task automatic send(int i, logic [31:0] w);
        bit r;
        valid_in = 1'b1;
        data_in = w;
        for (int n = 0; n < 20; n++) begin
            r = exp_ready(i);
            @(negedge clk);
            if (r) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit take;

        // Reset state, SYNC, and a word pending during SYNC.
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        live = 1;
        pin(0, "reset_i0", 8'h00, 8'h00, 0, 0, 0);
        pin(1, "reset_i1", 8'h00, 8'h00, 0, 0, 0);
        reset_L = 1'b1;
        valid_in = 1'b1;
        data_in = 32'hF4FFEF7F;
        for (int c = 0; c < SYNC; c++) begin
            @(negedge clk);
            pin(0, "sync_com", 8'hBC, 8'hBC, 1, 0, 0);
        end
        @(negedge clk);
        pin(0, "sync_end_idle", 8'h7C, 8'h7C, 1, 1, 1);
        @(negedge clk);
        pin(0, "held_word_hi", 8'hF4, 8'hFF, 0, 1, 0);
        valid_in = 1'b0;
        @(negedge clk);
        pin(0, "held_word_lo", 8'hEF, 8'h7F, 0, 1, 1);
        @(negedge clk);
        pin(0, "idle_after", 8'h7C, 8'h7C, 1, 1, 1);

        // Back-to-back words with valid held.
        valid_in = 1'b1;
        data_in = 32'hE8EEE4EE;
        @(negedge clk);
        pin(0, "b2b_hi1", 8'hE8, 8'hEE, 0, 1, 0);
        data_in = 32'hD4DDD77D;
        @(negedge clk);
        pin(0, "b2b_lo1", 8'hE4, 8'hEE, 0, 1, 1);
        pin(1, "i1_lo_due", 8'hE4, 8'hEE, 0, 1, 0);
        @(negedge clk);
        pin(0, "b2b_hi2", 8'hD4, 8'hDD, 0, 1, 0);
        pin(1, "i1_com", 8'hBC, 8'hBC, 1, 1, 1);
        valid_in = 1'b0;
        @(negedge clk);
        pin(0, "b2b_lo2", 8'hD7, 8'h7D, 0, 1, 1);

        // Forced COM slot every two words.
        do_reset();
        send(1, 32'h11223344);
        send(1, 32'h55667788);
        data_in = 32'h8CCC1CCC;
        @(negedge clk);
        pin(1, "com_lo_due", 8'h77, 8'h88, 0, 1, 0);
        @(negedge clk);
        pin(1, "com_slot", 8'hBC, 8'hBC, 1, 1, 1);
        @(negedge clk);
        pin(1, "com_next_hi", 8'h8C, 8'hCC, 0, 1, 0);
        valid_in = 1'b0;
        @(negedge clk);
        pin(1, "com_next_lo", 8'h1C, 8'hCC, 0, 1, 1);

        // Reset in the middle of a word.
        do_reset();
        valid_in = 1'b1;
        data_in = 32'hF4FFEF7F;
        @(negedge clk);
        pin(0, "mid_hi", 8'hF4, 8'hFF, 0, 1, 0);
        valid_in = 1'b0;
        reset_L = 1'b0;
        @(negedge clk);
        pin(0, "mid_reset", 8'h00, 8'h00, 0, 0, 0);
        reset_L = 1'b1;
        @(negedge clk);
        pin(0, "mid_resync", 8'hBC, 8'hBC, 1, 0, 0);

        // Randomized traffic, source follows instance 0's handshake, occasional reset.
        for (int c = 0; c < 4000; c++) begin
            take = valid_in && exp_ready(0);
            @(negedge clk);
            if (take || !valid_in) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in = $urandom;
            end
            reset_L = ($urandom_range(0, 299) != 0);
        end
        reset_L = 1'b1;
        valid_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
